axis_arb: RTL

AXIS_ARB -- requirements
Module: axis_arb

---
 rtl/axis_pkg.sv | 5 +
 rtl/axis_rr_sel.sv | 29 ++
 rtl/axis_arb.sv | 124 ++++++++++++
 3 files changed

// File: rtl/axis_pkg.sv
// axis_pkg: shared FSM state type and counter width for the AXI-Stream packet arbiter
package axis_pkg;
  typedef enum logic {IDLE, XFER} t_axis_arb_state;
  localparam int AXIS_ARB_CNT_W = 16;
endpackage

// File: rtl/axis_rr_sel.sv
// axis_rr_sel: combinational round-robin pick, first requester at or above ptr with wrap-around
//   req    : per-port request vector
//   ptr    : index where the search starts
//   gnt_id : winning index (0 when nothing requests)
//   gnt_vld: at least one request present
module axis_rr_sel #(
  parameter int NUM_PORTS = 4,
  localparam int IW = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IW-1:0]        ptr,
  output logic [IW-1:0]        gnt_id,
  output logic                 gnt_vld
);
  logic [IW-1:0] idx;
  // Walk offsets from farthest to nearest so the nearest requester is the last one written.
  always_comb begin
    gnt_id = '0;
    gnt_vld = 1'b0;
    idx = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      idx = IW'((int'(ptr) + k) % NUM_PORTS);
      if (req[idx]) begin
        gnt_id = idx;
        gnt_vld = 1'b1;
      end
    end
  end
endmodule

// File: rtl/axis_arb.sv
// axis_arb: packet-granular round-robin arbiter merging NUM_PORTS AXI-Stream inputs into one registered output
//   clk, rst (async, active-low)
//   s_data/s_keep/s_user/s_last/s_valid : per-port slave streams, port i at slice i; s_ready back to each port
//   m_data/m_keep/m_user/m_last/m_valid : merged stream, one register stage; m_ready from downstream
//   grant_id : port owning the output (meaningful while busy); busy : a packet is locked
//   pkt_cnt  : per-port completed-packet counters, present only with AXIS_ARB_STATS_EN defined
module axis_arb
  import axis_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 32,
  parameter int USER_WIDTH = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]   s_data,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] s_keep,
  input  logic [NUM_PORTS*USER_WIDTH-1:0]   s_user,
  input  logic [NUM_PORTS-1:0]              s_last,
  input  logic [NUM_PORTS-1:0]              s_valid,
  output logic [NUM_PORTS-1:0]              s_ready,
  output logic [DATA_WIDTH-1:0]             m_data,
  output logic [DATA_WIDTH/8-1:0]           m_keep,
  output logic [USER_WIDTH-1:0]             m_user,
  output logic                              m_last,
  output logic                              m_valid,
  input  logic                              m_ready,
  output logic [$clog2(NUM_PORTS)-1:0]      grant_id,
  output logic                              busy
`ifdef AXIS_ARB_STATS_EN
  ,
  output logic [NUM_PORTS*AXIS_ARB_CNT_W-1:0] pkt_cnt
`endif
);
  localparam int IW = $clog2(NUM_PORTS);
  localparam int KW = DATA_WIDTH / 8;
  t_axis_arb_state state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d, grant_q, grant_d, sel_id;
  logic sel_vld, acc, acc_last;
  logic m_valid_q, m_valid_d, m_last_q, m_last_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic [KW-1:0] m_keep_q, m_keep_d;
  logic [USER_WIDTH-1:0] m_user_q, m_user_d;
  logic [DATA_WIDTH-1:0] d_arr [NUM_PORTS];
  logic [KW-1:0] k_arr [NUM_PORTS];
  logic [USER_WIDTH-1:0] u_arr [NUM_PORTS];
  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_unpack
    assign d_arr[i] = s_data[i*DATA_WIDTH +: DATA_WIDTH];
    assign k_arr[i] = s_keep[i*KW +: KW];
    assign u_arr[i] = s_user[i*USER_WIDTH +: USER_WIDTH];
  end
  axis_rr_sel #(.NUM_PORTS(NUM_PORTS)) u_rr_sel (
    .req(s_valid),
    .ptr(rr_ptr_q),
    .gnt_id(sel_id),
    .gnt_vld(sel_vld)
  );
  // Only the granted port may see ready, and only when the output register can take a beat.
  always_comb begin
    s_ready = '0;
    s_ready[grant_q] = (state_q == XFER) && (!m_valid_q || m_ready);
  end
  assign acc = s_valid[grant_q] && s_ready[grant_q];
  assign acc_last = acc && s_last[grant_q];
  always_comb begin
    state_d = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d = grant_q;
    if (state_q == IDLE && sel_vld) begin
      state_d = XFER;
      grant_d = sel_id;
    end
    if (acc_last) begin
      state_d = IDLE;
      rr_ptr_d = (grant_q == IW'(NUM_PORTS - 1)) ? '0 : grant_q + 1'b1;
    end
  end
  always_comb begin
    m_valid_d = acc || (m_valid_q && !m_ready);
    m_data_d = acc ? d_arr[grant_q] : m_data_q;
    m_keep_d = acc ? k_arr[grant_q] : m_keep_q;
    m_user_d = acc ? u_arr[grant_q] : m_user_q;
    m_last_d = acc ? s_last[grant_q] : m_last_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      rr_ptr_q <= '0;
      grant_q <= '0;
      m_valid_q <= 1'b0;
      m_last_q <= 1'b0;
      m_data_q <= '0;
      m_keep_q <= '0;
      m_user_q <= '0;
    end else begin
      state_q <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q <= grant_d;
      m_valid_q <= m_valid_d;
      m_last_q <= m_last_d;
      m_data_q <= m_data_d;
      m_keep_q <= m_keep_d;
      m_user_q <= m_user_d;
    end
  end
  assign m_valid = m_valid_q;
  assign m_last = m_last_q;
  assign m_data = m_data_q;
  assign m_keep = m_keep_q;
  assign m_user = m_user_q;
  assign grant_id = grant_q;
  assign busy = (state_q == XFER);
`ifdef AXIS_ARB_STATS_EN
  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_cnt
    logic [AXIS_ARB_CNT_W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = cnt_q + AXIS_ARB_CNT_W'(acc_last && grant_q == IW'(i));
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt_q <= '0;
      else cnt_q <= cnt_d;
    end
    assign pkt_cnt[i*AXIS_ARB_CNT_W +: AXIS_ARB_CNT_W] = cnt_q;
  end
`endif
endmodule
